// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Purpose:
//   Multi-cycle MEM-stage controller. Each 32-bit load or store from the
//   EXE/MEM register becomes two half-word accesses on a 16-bit SRAM.
//   The low half goes first, then the high half. Each half is held on the
//   pins for WAIT_CYCLES clocks. While an access is in flight, ready is low
//   so the hazard logic freezes every pipeline register. In the DONE cycle
//   the assembled load word is presented on read_data.
//
// Optional feature (macro SRAM_RANGE_CHECK_EN):
//   When the macro is defined, an access is out of range if either
//   condition holds:
//     - the address is below ADDR_BASE, or
//     - the word index does not fit in SRAM_AW-1 bits.
//   Such an access skips straight to DONE without any SRAM strobe and
//   pulses range_err. A load of this kind returns 0.
//   Without the macro, range_err is tied 0 and addresses are truncated.
//
// Ports:
//   clk, rst     clock (posedge), asynchronous active-high reset
//   rd_en, wr_en load / store request (store wins if both are high)
//   address      byte address
//   write_data   store data
//   ready        1 = pipeline may advance, 0 = freeze
//   read_data    assembled load word, held until the next load completes
//   sram_addr    SRAM half-word address {word_idx, half}
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_we_n    SRAM write strobe, active low
//   range_err    out-of-range pulse in DONE (macro builds only)
// -----------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int ADDR_BASE   = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic               ready,
   output logic [31:0]        read_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               range_err
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
   localparam int WW = SRAM_AW - 1;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [31:0]    lat_addr;
   logic [15:0]    lat_data_hi;   // the low half is driven straight from write_data
   logic           lat_wr;
   logic [15:0]    lo_buf;        // low half parked here so read_data changes only at completion
   logic           req;
   logic           last_cycle;
   logic           oor_in;
   logic [WW-1:0]  wi_in;
   logic [WW-1:0]  wi_lat;

   assign req        = rd_en | wr_en;
   assign last_cycle = (cnt == CNT_LAST);
   assign wi_in      = WW'((address  - 32'(ADDR_BASE)) >> 2);
   assign wi_lat     = WW'((lat_addr - 32'(ADDR_BASE)) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
   logic [31:0] offs_in;
   assign offs_in = address - 32'(ADDR_BASE);
   assign oor_in  = (address < 32'(ADDR_BASE)) || ((offs_in >> 2) >= (32'd1 << WW));
`else
   assign oor_in    = 1'b0;
   assign range_err = 1'b0;
`endif

   // ready is combinational in IDLE, so the request cycle itself freezes the pipeline.
   always_comb begin
      ready = 1'b0;
      case (state)
         S_IDLE:  ready = ~req;
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         lat_addr    <= '0;
         lat_data_hi <= '0;
         lat_wr      <= 1'b0;
         lo_buf      <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
         range_err   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef SRAM_RANGE_CHECK_EN
               range_err <= 1'b0;
`endif
               if (req) begin
                  lat_addr    <= address;
                  lat_data_hi <= write_data[31:16];
                  lat_wr      <= wr_en;
                  cnt         <= '0;
                  if (oor_in) begin
                     // Out-of-range: no strobes, complete on the next cycle.
                     state <= S_DONE;
                     if (!wr_en) read_data <= '0;
`ifdef SRAM_RANGE_CHECK_EN
                     range_err <= 1'b1;
`endif
                  end else begin
                     state       <= S_LO;
                     sram_addr   <= {wi_in, 1'b0};
                     sram_dq_out <= write_data[15:0];
                     sram_dq_oe  <= wr_en;
                     sram_we_n   <= ~wr_en;
                  end
               end
            end

            S_LO: begin
               if (last_cycle) begin
                  cnt         <= '0;
                  state       <= S_HI;
                  sram_addr   <= {wi_lat, 1'b1};
                  sram_dq_out <= lat_data_hi;
                  if (!lat_wr) lo_buf <= sram_dq_in;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_HI: begin
               if (last_cycle) begin
                  cnt        <= '0;
                  state      <= S_DONE;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!lat_wr) read_data <= {sram_dq_in, lo_buf};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               // The request is still asserted here; it is never restarted.
               state <= S_IDLE;
`ifdef SRAM_RANGE_CHECK_EN
               range_err <= 1'b0;
`endif
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Purpose:
//   Self-checking bench for sram_mem_controller.
//   - The bench includes a 16-bit SRAM device model.
//   - A transaction-level reference model tracks three things: the 32-bit
//     word stored at each word index, the held SRAM address and the last
//     load result.
//   - For every driven cycle, the driver pushes the expected pin values.
//   - On each falling edge, one compare process pops an entry and checks
//     every output against it.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

   localparam int WAIT = 2;

   logic        clk;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic        ready;
   logic [31:0] read_data;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n, range_err;

   sram_mem_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(WAIT), .SRAM_AW(18)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .ready      (ready),
      .read_data  (read_data),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in (sram_dq_in),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n),
      .range_err  (range_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- SRAM device ----------------
   logic [15:0] dev_mem [0:262143];

   function automatic logic [15:0] pat(input int a);
      return 16'((a ^ (a >> 7)) * 29 + 7);
   endfunction

   initial begin
      for (int i = 0; i < 262144; i++) dev_mem[i] = pat(i);
   end

   always @(posedge clk) begin
      if (!sram_we_n) dev_mem[sram_addr] <= sram_dq_out;
   end

   assign sram_dq_in = dev_mem[sram_addr];

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        ready;
      logic        we_n;
      logic        oe;
      logic        chk_dq;
      logic [17:0] addr;
      logic [15:0] dq;
      logic [31:0] rdata;
      logic        rerr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [int];
   logic [17:0] m_addr;
   logic [31:0] m_rdata;
   int          n_checks;
   int          n_fail;

   function automatic int model_wi(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'd1024;
      return int'((off >> 2) & 32'h1FFFF);
   endfunction

   function automatic bit model_in_range(input logic [31:0] a);
      return (a >= 32'd1024) && (((a - 32'd1024) >> 2) < 32'h20000);
   endfunction

   function automatic logic [31:0] ref_read(input int wi);
      if (ref_mem.exists(wi)) return ref_mem[wi];
      return {pat(2 * wi + 1), pat(2 * wi)};
   endfunction

   function automatic exp_t mk(input logic rdy, input logic we_n, input logic oe,
                               input logic chk_dq, input logic [17:0] addr,
                               input logic [15:0] dq, input logic [31:0] rdata,
                               input logic rerr);
      exp_t e;
      e.ready = rdy; e.we_n = we_n; e.oe = oe; e.chk_dq = chk_dq;
      e.addr = addr; e.dq = dq; e.rdata = rdata; e.rerr = rerr;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ready",     32'(ready),     32'(e.ready));
         chk("sram_we_n", 32'(sram_we_n), 32'(e.we_n));
         chk("sram_dq_oe",32'(sram_dq_oe),32'(e.oe));
         chk("sram_addr", 32'(sram_addr), 32'(e.addr));
         chk("read_data", read_data,      e.rdata);
         chk("range_err", 32'(range_err), 32'(e.rerr));
         if (e.chk_dq) chk("sram_dq_out", 32'(sram_dq_out), 32'(e.dq));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      address    = $urandom;
      write_data = $urandom;
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, m_addr, 16'h0, m_rdata, 1'b0));
      step();
   endtask

   // One load/store, held until DONE. abort_hi asserts rst in the first HI cycle.
   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input bit abort_hi);
      int          wi;
      logic [31:0] old;
      wi         = model_wi(a);
      wr_en      = wr;
      rd_en      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      address    = a;
      write_data = d;
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, m_addr, 16'h0, m_rdata, 1'b0));
      step();
`ifdef SRAM_RANGE_CHECK_EN
      if (!model_in_range(a)) begin
         if (!wr) m_rdata = 32'h0;
         exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, m_addr, 16'h0, m_rdata, 1'b1));
         step();
         return;
      end
`endif
      for (int i = 0; i < WAIT; i++) begin
         exp_q.push_back(mk(1'b0, !wr, wr, wr, 18'(2 * wi), d[15:0], m_rdata, 1'b0));
         step();
      end
      if (abort_hi) begin
         rst     = 1'b1;
         rd_en   = 1'b0;
         wr_en   = 1'b0;
         m_addr  = '0;
         m_rdata = '0;
         if (wr) begin
            old         = ref_read(wi);
            ref_mem[wi] = {old[31:16], d[15:0]};
         end
         exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 32'h0, 1'b0));
         step();
         rst = 1'b0;
         return;
      end
      for (int i = 0; i < WAIT; i++) begin
         exp_q.push_back(mk(1'b0, !wr, wr, wr, 18'(2 * wi + 1), d[31:16], m_rdata, 1'b0));
         step();
      end
      if (wr) ref_mem[wi] = d;
      else    m_rdata     = ref_read(wi);
      m_addr = 18'(2 * wi + 1);
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, m_addr, 16'h0, m_rdata, 1'b0));
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a, d;
      bit          wr;
      n_checks   = 0;
      n_fail     = 0;
      m_addr     = '0;
      m_rdata    = '0;
      rst        = 1'b1;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      address    = '0;
      write_data = '0;
      step();

      // Reset and idle behaviour
      repeat (3) idle_cycle();
      rst = 1'b0;
      repeat (3) idle_cycle();

      // Store 0xDEADBEEF to 1028
      access(1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
      chk("dev_lo_1028", 32'(dev_mem[2]), 32'h0000BEEF);
      chk("dev_hi_1028", 32'(dev_mem[3]), 32'h0000DEAD);

      // Load from 1028
      access(1'b0, 32'd1028, $urandom, 1'b0);
      chk("load_1028", read_data, 32'hDEADBEEF);
      idle_cycle();

      // Store immediately followed by a load of the same word
      access(1'b1, 32'd1024, 32'h12345678, 1'b0);
      access(1'b0, 32'd1024, 32'h0, 1'b0);
      chk("load_1024", read_data, 32'h12345678);
      idle_cycle();

      // Reset during the HI phase of a write: only the low half lands
      access(1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
      idle_cycle();
      access(1'b0, 32'd1032, 32'h0, 1'b0);
      chk("partial_lo", 32'(read_data[15:0]), 32'h0000F00D);
      idle_cycle();

      // Below-base load at 512
      access(1'b0, 32'd512, 32'h0, 1'b0);
`ifndef SRAM_RANGE_CHECK_EN
      chk("addr_512", 32'(sram_addr), 32'h0003FF01);
`endif
      chk("rerr_512", 32'(range_err), 32'h0);
      idle_cycle();

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 2)) idle_cycle();
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 9) == 0) ? $urandom : (32'd1024 + 32'(4 * $urandom_range(0, 31)));
         d  = $urandom;
         access(wr, a, d, 1'b0);
      end
      repeat (3) idle_cycle();

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
